// File: rtl/conv2d_kxk_filter.sv
// KSIZE x KSIZE 2D convolution on a raster pixel stream with double-buffered runtime coefficients.
// Optional define CONV2D_ROUND_EN: add half an LSB before the scale shift (default truncates).
module conv2d_kxk_filter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned KSIZE    = 5,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned SHIFT    = 4,
  parameter int unsigned MAX_COLS = 1600
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              y_i,
  input  logic                           dv_i,
  input  logic                           hs_i,
  input  logic                           vs_i,
  input  logic                           coef_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0] coef_addr,
  input  logic [COEF_W-1:0]              coef_din,
  output logic [DATA_W-1:0]              r_o,
  output logic [DATA_W-1:0]              g_o,
  output logic [DATA_W-1:0]              b_o,
  output logic                           dv_o,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic                           ovf_o
);
  localparam int unsigned KK     = KSIZE * KSIZE;
  localparam int unsigned NBUF   = KSIZE - 1;
  localparam int unsigned H      = (KSIZE - 1) / 2;
  localparam int unsigned LAT    = 5;
  localparam int unsigned AW     = $clog2(MAX_COLS);
  localparam int unsigned COL_W  = AW + 1;
  localparam int unsigned ROW_W  = 11;
  localparam int unsigned WS_W   = $clog2(NBUF);
  localparam int unsigned PROD_W = DATA_W + 1 + COEF_W;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + 1 + $clog2(KK);
  localparam int unsigned CENTRE = (KK - 1) / 2;
`ifdef CONV2D_ROUND_EN
  localparam int unsigned RND    = (1 << SHIFT) >> 1;
`else
  localparam int unsigned RND    = 0;
`endif
  localparam logic signed [ACC_W-1:0]  RND_A   = ACC_W'(RND);
  localparam logic signed [ACC_W-1:0]  PIX_MAX = ACC_W'((1 << DATA_W) - 1);
  localparam logic signed [COEF_W-1:0] ID_COEF = COEF_W'(1 << SHIFT);

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [WS_W-1:0]          ws, ws_d;
  logic                     in_range_c, zero_c;
  logic [AW-1:0]            addr_c;
  logic [DATA_W-1:0]        lbuf [NBUF][MAX_COLS];
  logic [DATA_W-1:0]        rd [NBUF];
  logic [DATA_W-1:0]        y_d;
  logic [DATA_W-1:0]        newcol_c [KSIZE];
  logic [DATA_W-1:0]        win [KSIZE][KSIZE-1];
  logic [DATA_W-1:0]        tap_c [KK];
  logic signed [COEF_W-1:0] coef_sh [KK];
  logic signed [COEF_W-1:0] coef_act [KK];
  logic signed [PROD_W-1:0] prod [KK];
  logic signed [ACC_W-1:0]  acc_c, acc, scaled;
  logic [2:0]               tim [LAT];
  logic [LAT-2:0]           zq;
  logic [DATA_W-1:0]        pix;

  assign in_range_c = (col < COL_W'(MAX_COLS));
  assign zero_c     = (row < ROW_W'(2 * H)) || (col < COL_W'(2 * H)) || !in_range_c;
  assign addr_c     = in_range_c ? col[AW-1:0] : '0;

  // Raster position, line-buffer write select and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      ws    <= '0;
      ovf_o <= 1'b0;
    end else if (vs_i) begin
      col   <= '0;
      row   <= '0;
      ws    <= '0;
      ovf_o <= 1'b0;
    end else if (hs_i) begin
      col <= '0;
      if (row != '1) row <= row + 1'b1;
      ws  <= (ws == WS_W'(NBUF - 1)) ? '0 : ws + 1'b1;
    end else if (dv_i) begin
      if (col != '1) col <= col + 1'b1;
      if (!in_range_c) ovf_o <= 1'b1;
    end
  end

  // Line buffers are read-first: the slot being overwritten still supplies the oldest row
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBUF; b++) rd[b] <= lbuf[b][addr_c];
    if (dv_i && in_range_c && !hs_i && !vs_i) lbuf[ws][addr_c] <= y_i;
  end

  // Shadow bank takes writes; active bank reloads from the pre-write shadow at frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < KK; k++) begin
        coef_sh[k]  <= (k == CENTRE) ? ID_COEF : '0;
        coef_act[k] <= (k == CENTRE) ? ID_COEF : '0;
      end
    end else begin
      if (coef_we && (32'(coef_addr) < KK)) coef_sh[coef_addr] <= coef_din;
      if (vs_i) for (int k = 0; k < KK; k++) coef_act[k] <= coef_sh[k];
    end
  end

  // New window column: buffers reordered oldest-first, live pixel at the bottom
  always_comb begin
    for (int i = 0; i < KSIZE; i++) newcol_c[i] = y_d;
    for (int i = 0; i < NBUF; i++) newcol_c[i] = rd[WS_W'((32'(ws_d) + 32'(i)) % NBUF)];
  end

  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE - 1; j++) tap_c[i*KSIZE+j] = win[i][j];
      tap_c[i*KSIZE+KSIZE-1] = newcol_c[i];
    end
  end

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < KK; k++) acc_c = acc_c + ACC_W'(prod[k]);
  end

  // Five-stage datapath: capture, multiply, sum, scale, saturate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_d    <= '0;
      ws_d   <= '0;
      zq     <= '0;
      acc    <= '0;
      scaled <= '0;
      pix    <= '0;
      for (int k = 0; k < LAT; k++) tim[k] <= '0;
      for (int k = 0; k < KK; k++) prod[k] <= '0;
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE - 1; j++) win[i][j] <= '0;
    end else begin
      y_d    <= y_i;
      ws_d   <= ws;
      zq     <= {zq[LAT-3:0], zero_c};
      tim[0] <= {dv_i, hs_i, vs_i};
      for (int k = 1; k < LAT; k++) tim[k] <= tim[k-1];
      if (tim[0][2]) begin
        for (int i = 0; i < KSIZE; i++) begin
          for (int j = 0; j < KSIZE - 2; j++) win[i][j] <= win[i][j+1];
          win[i][KSIZE-2] <= newcol_c[i];
        end
      end
      for (int k = 0; k < KK; k++)
        prod[k] <= PROD_W'($signed({1'b0, tap_c[k]})) * PROD_W'(coef_act[k]);
      acc    <= acc_c;
      scaled <= (acc + RND_A) >>> SHIFT;
      if (tim[LAT-2][2]) begin
        if (zq[LAT-2] || scaled[ACC_W-1]) pix <= '0;
        else if (scaled > PIX_MAX)        pix <= '1;
        else                              pix <= scaled[DATA_W-1:0];
      end
    end
  end

  assign r_o = pix;
  assign g_o = pix;
  assign b_o = pix;
  assign {dv_o, hs_o, vs_o} = tim[LAT-1];

endmodule
